// File: rtl/adder_sum_accumulator_if.sv
// rtl/adder_sum_accumulator_if.sv - sample-in / block-sum-out handshake bundle
//
// Purpose: groups the sample stream and result stream of adder_sum_accumulator.
// Signal names are from the accumulator's point of view.
//   sum_i        WIDTH  signed sample from the adder
//   sum_valid_i  1      sum_i valid this cycle
//   sum_ready_o  1      accumulator can take a sample
//   acc_o        WIDTH  signed saturated block sum
//   acc_valid_o  1      acc_o valid
//   acc_ready_i  1      consumer takes acc_o
//   sat_o        1      current acc_o was clipped
// Modports: master = producer/consumer side, slave = accumulator side.
interface adder_sum_accumulator_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] sum_i;
  logic             sum_valid_i;
  logic             sum_ready_o;
  logic [WIDTH-1:0] acc_o;
  logic             acc_valid_o;
  logic             acc_ready_i;
  logic             sat_o;

  modport master (
    output sum_i, sum_valid_i, acc_ready_i,
    input  sum_ready_o, acc_o, acc_valid_o, sat_o
  );

  modport slave (
    input  sum_i, sum_valid_i, acc_ready_i,
    output sum_ready_o, acc_o, acc_valid_o, sat_o
  );
endinterface

// File: rtl/adder_sum_accumulator.sv
// rtl/adder_sum_accumulator.sv - block accumulator with saturated valid/ready result
//
// Purpose: sums COUNT accepted signed samples in an ACC_WIDTH accumulator, then
// presents the total saturated to WIDTH bits until the consumer takes it.
// Ports:
//   clk_i         clock, rising edge
//   rst_n_i       asynchronous active-low reset
//   clear_i       synchronous flush of the partial block and any pending result
//   ovf_sticky_o  a dumped result has saturated since reset/clear
//   bus           adder_sum_accumulator_if.slave (sample in, result out)
module adder_sum_accumulator #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 40,
  parameter int COUNT     = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  output logic ovf_sticky_o,
  adder_sum_accumulator_if.slave bus
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DUMP  = 1'b1
  } state_e;

  state_e               state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     acc_o_q;
  logic [WIDTH-1:0]     sat_val_d;
  logic                 sat_d;
  logic                 sat_q;
  logic                 valid_q;
  logic                 sticky_q;
  logic [ACC_WIDTH-WIDTH:0] top_bits;

  // Running total including the sample currently on the bus.
  always_comb begin
    acc_d     = acc_q + {{(ACC_WIDTH-WIDTH){bus.sum_i[WIDTH-1]}}, bus.sum_i};
    top_bits  = acc_d[ACC_WIDTH-1:WIDTH-1];
    // The total fits in WIDTH bits only when every bit from WIDTH-1 up is a
    // copy of the sign; any disagreement means clipping.
    sat_d     = ~(&top_bits) & (|top_bits);
    sat_val_d = acc_d[WIDTH-1:0];
    if (sat_d) begin
      sat_val_d = acc_d[ACC_WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      acc_o_q  <= '0;
      sat_q    <= 1'b0;
      valid_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else if (clear_i) begin
      // acc_o_q deliberately keeps its last value; a sample on the bus is dropped.
      state_q  <= ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      valid_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.sum_valid_i) begin
            if (cnt_q == LAST_CNT) begin
              acc_o_q  <= sat_val_d;
              sat_q    <= sat_d;
              sticky_q <= sticky_q | sat_d;
              acc_q    <= '0;
              cnt_q    <= '0;
              valid_q  <= 1'b1;
              state_q  <= DUMP;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        DUMP: begin
          if (bus.acc_ready_i) begin
            valid_q <= 1'b0;
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  // Ready depends on state alone, so there is no path from acc_ready_i.
  assign bus.sum_ready_o = (state_q == ACCUM);
  assign bus.acc_o       = acc_o_q;
  assign bus.acc_valid_o = valid_q;
  assign bus.sat_o       = sat_q;
  assign ovf_sticky_o    = sticky_q;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// tb/tb_adder_sum_accumulator.sv - scoreboard bench for adder_sum_accumulator
module tb_adder_sum_accumulator;

  localparam int W    = 8;
  localparam int AW   = 12;
  localparam int CNT  = 4;
  localparam int MAXV = (1 << (W-1)) - 1;
  localparam int MINV = -(1 << (W-1));

  logic clk = 1'b0;
  logic rst_n_i;
  logic clear_i;
  logic ovf_sticky_o;

  adder_sum_accumulator_if #(.WIDTH(W)) bus ();

  adder_sum_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .COUNT(CNT)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .clear_i      (clear_i),
    .ovf_sticky_o (ovf_sticky_o),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    bit sat;
    bit sticky;
  } exp_t;

  exp_t exp_q[$];
  int   blk[$];
  bit   sticky_m;
  bit   rnd_rdy;
  int   n_checks;
  int   n_fail;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a block is a list of accepted samples; its result is the
  // plain integer sum clamped to the signed WIDTH range.
  task automatic model_accept(input int v);
    int   total;
    exp_t e;
    blk.push_back(v);
    if (blk.size() == CNT) begin
      total = 0;
      foreach (blk[i]) total += blk[i];
      e.sat = (total > MAXV) || (total < MINV);
      e.acc = (total > MAXV) ? MAXV : (total < MINV) ? MINV : total;
      sticky_m = sticky_m | e.sat;
      e.sticky = sticky_m;
      exp_q.push_back(e);
      blk.delete();
    end
  endtask

  task automatic model_clear();
    blk.delete();
    exp_q.delete();
    sticky_m = 1'b0;
  endtask

  // Monitor: a result is consumed on any cycle with valid & ready and no flush.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n_i && bus.acc_valid_o && bus.acc_ready_i && !clear_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("acc_o", int'($signed(bus.acc_o)), e.acc);
          check("sat_o", int'(bus.sat_o), int'(e.sat));
          check("ovf_sticky_o", int'(ovf_sticky_o), int'(e.sticky));
        end
      end
    end
  end

  // Offer one sample until accepted; called and returns at posedge+1.
  task automatic send(input int v);
    bit acc_ok;
    acc_ok = 1'b0;
    bus.sum_i       = W'(v);
    bus.sum_valid_i = 1'b1;
    for (int t = 0; t < 50 && !acc_ok; t++) begin
      if (rnd_rdy) bus.acc_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc_ok = bus.sum_ready_o && !clear_i;
      @(posedge clk);
      #1;
    end
    if (acc_ok) model_accept(v);
    else check("send_timeout", 0, 1);
  endtask

  task automatic send_block(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
    bus.sum_valid_i = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acc_o"}, int'(bus.acc_o), 0);
    check({tag, "_valid"}, int'(bus.acc_valid_o), 0);
    check({tag, "_sat"}, int'(bus.sat_o), 0);
    check({tag, "_sticky"}, int'(ovf_sticky_o), 0);
    check({tag, "_ready"}, int'(bus.sum_ready_o), 1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sticky_m = 1'b0;
    rnd_rdy  = 1'b0;
    rst_n_i  = 1'b0;
    clear_i  = 1'b0;
    bus.sum_i       = '0;
    bus.sum_valid_i = 1'b0;
    bus.acc_ready_i = 1'b1;

    // Reset values.
    #3;
    check_reset_outputs("reset");
    cycle(); cycle();
    rst_n_i = 1'b1;
    cycle();

    // Back-to-back block; ready low exactly one cycle, valid one cycle.
    send_block(10, 20, -5, 7);
    @(negedge clk);
    check("t2_ready_low", int'(bus.sum_ready_o), 0);
    check("t2_valid_high", int'(bus.acc_valid_o), 1);
    cycle();
    @(negedge clk);
    check("t2_ready_back", int'(bus.sum_ready_o), 1);
    check("t2_valid_gone", int'(bus.acc_valid_o), 0);
    cycle();

    // Saturation both directions, sticky behaviour.
    send_block(100, 100, 100, 100);
    send_block(1, 1, 1, 1);
    send_block(-128, -128, -128, -128);
    send_block(-100, 50, -20, -10);
    cycle(); cycle();

    // Stall: result held, nothing consumed while ready is low.
    bus.acc_ready_i = 1'b0;
    send_block(1, 2, 3, 4);
    bus.sum_i       = W'(9);
    bus.sum_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_acc_hold", int'($signed(bus.acc_o)), 10);
      check("t5_ready_low", int'(bus.sum_ready_o), 0);
      check("t5_valid", int'(bus.acc_valid_o), 1);
      cycle();
    end
    bus.acc_ready_i = 1'b1;
    send(9);
    send(1); send(1); send(1);
    bus.sum_valid_i = 1'b0;
    cycle(); cycle();

    // Clear after two samples.
    send(5); send(6);
    bus.sum_valid_i = 1'b0;
    clear_i = 1'b1;
    cycle();
    clear_i = 1'b0;
    model_clear();
    check("t6_sticky_cleared", int'(ovf_sticky_o), 0);
    send_block(1, 2, 3, 4);

    // Clear together with a valid sample drops that sample.
    send(7); send(7);
    bus.sum_i       = W'(50);
    bus.sum_valid_i = 1'b1;
    clear_i         = 1'b1;
    cycle();
    clear_i         = 1'b0;
    bus.sum_valid_i = 1'b0;
    model_clear();
    send_block(1, 1, 1, 1);
    cycle(); cycle();

    // Clear during DUMP.
    bus.acc_ready_i = 1'b0;
    send_block(2, 2, 2, 2);
    @(negedge clk);
    check("t6_dump_valid", int'(bus.acc_valid_o), 1);
    clear_i = 1'b1;
    cycle();
    clear_i = 1'b0;
    model_clear();
    check("t6_clr_valid", int'(bus.acc_valid_o), 0);
    check("t6_clr_acc_hold", int'($signed(bus.acc_o)), 8);
    check("t6_clr_ready", int'(bus.sum_ready_o), 1);
    bus.acc_ready_i = 1'b1;

    // Randomized traffic with random consumer back-pressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.sum_valid_i = 1'b0;
        cycle();
      end
      send(int'($urandom_range(0, 255)) - 128);
    end
    rnd_rdy = 1'b0;
    bus.sum_valid_i = 1'b0;
    bus.acc_ready_i = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) cycle();
    check("rnd_drained", exp_q.size(), 0);

    // Asynchronous reset mid-block.
    send(1); send(2);
    bus.sum_valid_i = 1'b0;
    #3;
    rst_n_i = 1'b0;
    #1;
    model_clear();
    check_reset_outputs("t7_midblock");
    cycle();
    rst_n_i = 1'b1;
    cycle();

    // Asynchronous reset during DUMP.
    bus.acc_ready_i = 1'b0;
    send_block(100, 100, 100, 100);
    check("t7_dump_valid", int'(bus.acc_valid_o), 1);
    check("t7_dump_sticky", int'(ovf_sticky_o), 1);
    #3;
    rst_n_i = 1'b0;
    #1;
    model_clear();
    check_reset_outputs("t7_dump");
    cycle();
    rst_n_i = 1'b1;
    bus.acc_ready_i = 1'b1;
    cycle();

    // A block after reset behaves normally.
    send_block(3, -1, 4, -1);
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) cycle();
    check("final_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
